// File: rtl/mskaes_job_arbiter.sv
// Round-robin job arbiter in front of a single masked AES-128 core.
// Issues one job at a time, captures the core's one-cycle result pulse into a
// held response buffer tagged with the owner id, and aborts jobs that hang.
module mskaes_job_arbiter #(
    parameter int d       = 2,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*128*d-1:0]  req_sh_plaintext,
    input  logic [NREQ*128*d-1:0]  req_sh_key,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [128*d-1:0]       resp_sh_ciphertext,
    output logic                   err_timeout,
    output logic                   busy,
    output logic                   core_valid_in,
    input  logic                   core_ready,
    input  logic                   core_cipher_valid,
    output logic [128*d-1:0]       core_sh_plaintext,
    output logic [128*d-1:0]       core_sh_key,
    input  logic [128*d-1:0]       core_sh_ciphertext
);
    localparam int SHW = 128;
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t            state_reg, state_next;
    logic [IDW-1:0]    rr_reg, rr_next;
    logic [IDW-1:0]    cur_id_reg, cur_id_next;
    logic [9:0]        wdog_reg, wdog_next;
    logic              resp_valid_reg, resp_valid_next;
    logic [IDW-1:0]    resp_id_reg, resp_id_next;
    logic [128*d-1:0]  resp_ct_reg, resp_ct_next;
    logic              err_reg, err_next;

    logic              issue;
    logic              capture;
    logic              grant_found;
    logic [IDW-1:0]    grant_id;
    logic [IDW-1:0]    scan_cand;
    int                scan_idx;

    // Share-sliced views of each requester's data; muxing happens per share,
    // so the two halves of a sharing never meet in the same logic cone.
    logic [SHW-1:0] pt_sh  [NREQ][d];
    logic [SHW-1:0] key_sh [NREQ][d];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        for (genvar gj = 0; gj < d; gj++) begin : g_sh
            assign pt_sh[gi][gj]  = req_sh_plaintext[(gi*d + gj)*SHW +: SHW];
            assign key_sh[gi][gj] = req_sh_key[(gi*d + gj)*SHW +: SHW];
        end
    end

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_id    = '0;
        grant_found = 1'b0;
        scan_idx    = 0;
        scan_cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx  = (int'(rr_reg) + k) % NREQ;
            scan_cand = IDW'(scan_idx);
            if (!grant_found && req_valid[scan_cand]) begin
                grant_found = 1'b1;
                grant_id    = scan_cand;
            end
        end
    end

    // A full buffer that is not draining blocks issue, so the core's
    // unbuffered result pulse always has somewhere to land.
    assign issue   = (state_reg == ST_IDLE) && grant_found && core_ready &&
                     (!resp_valid_reg || resp_ready);
    assign capture = (state_reg == ST_BUSY) && core_cipher_valid;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
        assign req_ready[gi] = issue && (grant_id == IDW'(gi));
    end

    for (genvar gi = 0; gi < d; gi++) begin : g_core_mux
        assign core_sh_plaintext[gi*SHW +: SHW] = issue ? pt_sh[grant_id][gi]  : '0;
        assign core_sh_key[gi*SHW +: SHW]       = issue ? key_sh[grant_id][gi] : '0;
    end

    assign core_valid_in      = issue;
    assign busy               = (state_reg == ST_BUSY);
    assign resp_valid         = resp_valid_reg;
    assign resp_id            = resp_id_reg;
    assign resp_sh_ciphertext = resp_ct_reg;
    assign err_timeout        = err_reg;

    // Next-state: job lifecycle, watchdog, and response buffer fill/drain.
    always_comb begin
        state_next      = state_reg;
        rr_next         = rr_reg;
        cur_id_next     = cur_id_reg;
        wdog_next       = wdog_reg;
        resp_valid_next = resp_valid_reg;
        resp_id_next    = resp_id_reg;
        resp_ct_next    = resp_ct_reg;
        err_next        = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (issue) begin
                    state_next  = ST_BUSY;
                    cur_id_next = grant_id;
                    rr_next     = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                    wdog_next   = '0;
                end
            end
            ST_BUSY: begin
                // A result arriving on the last watchdog cycle still wins.
                if (core_cipher_valid) begin
                    state_next = ST_IDLE;
                end else if (wdog_reg == WD_LAST) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end else begin
                    wdog_next = wdog_reg + 10'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (capture) begin
            resp_valid_next = 1'b1;
            resp_id_next    = cur_id_reg;
            resp_ct_next    = core_sh_ciphertext;
        end else if (resp_valid_reg && resp_ready) begin
            resp_valid_next = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            rr_reg         <= '0;
            cur_id_reg     <= '0;
            wdog_reg       <= '0;
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= '0;
            resp_ct_reg    <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_reg         <= rr_next;
            cur_id_reg     <= cur_id_next;
            wdog_reg       <= wdog_next;
            resp_valid_reg <= resp_valid_next;
            resp_id_reg    <= resp_id_next;
            resp_ct_reg    <= resp_ct_next;
            err_reg        <= err_next;
        end
    end

endmodule

// File: doc/mskaes_job_arbiter.md
# mskaes_job_arbiter

Round-robin job arbiter that shares one masked round-based AES-128 core among `NREQ` requesters. Each requester submits a shared plaintext and key pair, and the arbiter issues it to the core through the core's `valid_in`/`ready` handshake. It captures the one-cycle `cipher_valid`/`sh_ciphertext` pulse into a held response buffer tagged with the requester id, and supervises each job with a watchdog. It sits between the requester fabric and the masked AES core, with exactly one job in flight at any time.

## Interface
- `d`, 2: number of shares.
- `NREQ`, 4: number of requesters (2..16).
- `IDW`, 2: requester id width, equal to `$clog2(NREQ)`.
- `TIMEOUT`, 1023: maximum BUSY cycles before a job is aborted; 10-bit counter.
- `clk`  in  1  clock; the single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  per-requester job valid.
- `req_ready`  out  NREQ  one-hot grant; a job transfers when `req_valid[i] & req_ready[i]`.
- `req_sh_plaintext`  in  NREQ*128*d  requester i's plaintext at slice `[i*128*d +: 128*d]`.
- `req_sh_key`  in  NREQ*128*d  per-requester shared key, same slicing.
- `resp_valid`  out  1  response buffer full.
- `resp_ready`  in  1  response consumer accepts.
- `resp_id`  out  IDW  id of the requester that owns the response.
- `resp_sh_ciphertext`  out  128*d  held shared ciphertext.
- `err_timeout`  out  1  sticky watchdog flag; cleared only by `rst`.
- `busy`  out  1  high while a job is in flight.
- `core_valid_in`  out  1  to core `valid_in`.
- `core_ready`  in  1  from core `ready`.
- `core_cipher_valid`  in  1  from core `cipher_valid` (single-cycle pulse).
- `core_sh_plaintext`  out  128*d  to core.
- `core_sh_key`  out  128*d  to core.
- `core_sh_ciphertext`  in  128*d  from core; non-zero only during `core_cipher_valid`.

## Operation
- **States.**
  - IDLE: no job in flight.
  - BUSY: a job is in flight.
- **Issue condition.** `issue = IDLE & |req_valid & core_ready & (~resp_valid | resp_ready)`.
- **Grant selection.** On issue, the grant `g` is the first requester with `req_valid` set, searching from pointer `rr` upward and wrapping modulo NREQ.
- **Issue cycle effects.**
  - `req_ready` is one-hot at `g`; `core_valid_in` = 1.
  - The core data ports carry requester `g`'s shares, selected per share with no recombination.
  - Otherwise `req_ready` = 0, `core_valid_in` = 0, and the core data ports carry the all-zero sharing.
- **Registered at issue.** `cur_id <= g`, `rr <= (g+1) mod NREQ`, state goes to BUSY, and the watchdog count is cleared.
- **BUSY.** The watchdog increments each cycle. `req_ready` stays 0 and no second job is issued.
- **Completion.** On `core_cipher_valid` in BUSY:
  - `resp_sh_ciphertext <= core_sh_ciphertext`, `resp_id <= cur_id`, `resp_valid <= 1`.
  - State returns to IDLE.
- **Watchdog abort.** If the watchdog reaches TIMEOUT in BUSY without `core_cipher_valid`:
  - `err_timeout <= 1` and state returns to IDLE.
  - No response is produced and the job is lost.
  - Issue remains allowed afterwards.
- **Response drain.** `resp_valid` clears on `resp_valid & resp_ready`, unless a new capture occurs in the same cycle, in which case the new capture wins. The buffer holds its content until accepted.
- **Stray pulse.** `core_cipher_valid` in IDLE is ignored, and no buffer update occurs.
- **Response wins the pulse.** If the pulse and the watchdog limit coincide, the response is captured and `err_timeout` is not set.
- **Share hygiene.** Shares are never XOR-combined inside this block. All data muxes operate share-slice by share-slice.

## Timing
- **Reset values.** `rst` takes effect at the next rising edge.
  - Outputs: `req_ready` = 0, `core_valid_in` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_sh_ciphertext` = 0, `err_timeout` = 0, `busy` = 0.
  - Internal: `rr` = 0, state IDLE.
- **Reset mid-job.** Any in-flight job is discarded, and a `core_cipher_valid` arriving after reset is ignored. The integrator resets the core on the same cycle (core `nrst = ~rst`).
- **Combinational paths.** `req_ready` and `core_valid_in` are combinational from `req_valid`, `core_ready`, `resp_valid`, `resp_ready` and state, with no added issue latency.
- **Response latency.** `resp_valid` rises one cycle after `core_cipher_valid`.
- **`busy`.** High from the cycle after issue through the cycle of the completion pulse.
- **Back-to-back jobs.** The next issue may occur in the cycle after capture if `core_ready` = 1. Throughput is therefore one job per (core latency + 1) cycles.
- **Backpressure.** A full buffer with `resp_ready` = 0 blocks issue, so the unbuffered core pulse can never be dropped.

## Test plan
- **Single job (FIPS-197).** Requester 2 submits key 000102…0f and plaintext 00112233…ff, with d = 2 and random masks.
  - `req_ready` = 0100 in the issue cycle.
  - After the pulse: `resp_valid` = 1, `resp_id` = 2.
  - The XOR of the shares equals 69c4e0d86a7b0430d8cdb78070b4c55a.
- **Fairness.** All four requesters hold `req_valid` continuously, with `resp_ready` = 1.
  - Grants occur in order 0, 1, 2, 3, 0.
  - `resp_id` follows the same order, with no requester granted twice in a row.
- **Backpressure.** Hold `resp_ready` = 0 after the first response.
  - No second issue occurs, and `resp_sh_ciphertext` stays stable for 50 cycles.
  - Raising `resp_ready` drains the buffer, and issue occurs in that same cycle.
- **Timeout.** Stub the core so it never pulses, with TIMEOUT = 15.
  - `err_timeout` rises after 15 BUSY cycles and the state returns to IDLE.
  - A subsequent job with a working core completes normally, and `err_timeout` stays 1.
- **Reset mid-job.** Assert `rst` 5 cycles after issue.
  - All outputs take their reset values, and a later stray `core_cipher_valid` is ignored (`resp_valid` stays 0).
- **Core not ready.** Hold `core_ready` = 0 with `req_valid` = 0001.
  - `req_ready` = 0 and `core_valid_in` = 0 until `core_ready` rises.
  - The grant then goes to requester 0.
